// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage pipelined IEEE-754-style multiplier with RNE rounding and flags
// Operands with a zero exponent are treated as zero; results never go subnormal.
module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] o,
  output logic                  of,
  output logic                  uf,
  output logic                  nv,
  output logic                  nx
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int M  = FRAC_W + 1;
  localparam int P  = 2 * M;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] BIAS = {3'b000, {(EXP_W-1){1'b1}}};

  typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

  logic adv;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_sign_q, s1_sign_d;
  cls_e          s1_cls_q, s1_cls_d;
  logic [XW-1:0] s1_exp_q, s1_exp_d;
  logic [P-1:0]  s1_prod_q, s1_prod_d;

  logic          s2_valid_q, s2_valid_d;
  logic          s2_sign_q, s2_sign_d;
  cls_e          s2_cls_q, s2_cls_d;
  logic [XW-1:0] s2_exp_q, s2_exp_d;
  logic [M:0]    s2_mant_q, s2_mant_d;
  logic          s2_inexact_q, s2_inexact_d;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  o_q, o_d;
  logic          of_q, of_d;
  logic          uf_q, uf_d;
  logic          nv_q, nv_d;
  logic          nx_q, nx_d;

  // Global stall: every stage moves together whenever the output slot can drain.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic [M-1:0]      ma, mb;
  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_cls_d   = s1_cls_q;
    s1_exp_d   = s1_exp_q;
    s1_prod_d  = s1_prod_q;
    if (adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = sa ^ sb;
        if (a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero)) begin
          s1_cls_d = CLS_NAN;
        end else if (a_inf | b_inf) begin
          s1_cls_d = CLS_INF;
        end else if (a_zero | b_zero) begin
          s1_cls_d = CLS_ZERO;
        end else begin
          s1_cls_d = CLS_NUM;
        end
        s1_exp_d  = {2'b00, ea} + {2'b00, eb} - BIAS;
        s1_prod_d = {{M{1'b0}}, ma} * {{M{1'b0}}, mb};
      end
    end
  end

  logic [P-1:0]  norm;
  logic [XW-1:0] exp_n;
  logic [M-1:0]  mant;
  logic          guard, sticky, rnd;

  always_comb begin
    // Product of two [1,2) mantissas lies in [1,4): at most one position to normalise.
    norm   = s1_prod_q[P-1] ? s1_prod_q : {s1_prod_q[P-2:0], 1'b0};
    exp_n  = s1_exp_q + {{(XW-1){1'b0}}, s1_prod_q[P-1]};
    mant   = norm[P-1:M];
    guard  = norm[M-1];
    sticky = |norm[M-2:0];
    rnd    = guard & (sticky | mant[0]);

    s2_valid_d   = s2_valid_q;
    s2_sign_d    = s2_sign_q;
    s2_cls_d     = s2_cls_q;
    s2_exp_d     = s2_exp_q;
    s2_mant_d    = s2_mant_q;
    s2_inexact_d = s2_inexact_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d    = s1_sign_q;
        s2_cls_d     = s1_cls_q;
        s2_exp_d     = exp_n;
        s2_mant_d    = {1'b0, mant} + {{M{1'b0}}, rnd};
        s2_inexact_d = guard | sticky;
      end
    end
  end

  logic [XW-1:0]     exp_f;
  logic [FRAC_W-1:0] frac_f;
  logic              ovf, unf;

  always_comb begin
    // A rounding carry leaves 10..0 above the point; shift it back down one place.
    exp_f  = s2_exp_q + {{(XW-1){1'b0}}, s2_mant_q[M]};
    frac_f = s2_mant_q[M] ? s2_mant_q[FRAC_W:1] : s2_mant_q[FRAC_W-1:0];
    ovf    = ~exp_f[XW-1] & (exp_f[EXP_W] | (&exp_f[EXP_W-1:0]));
    unf    = exp_f[XW-1] | (exp_f == '0);

    out_valid_d = out_valid_q;
    o_d         = o_q;
    of_d        = of_q;
    uf_d        = uf_q;
    nv_d        = nv_q;
    nx_d        = nx_q;
    if (adv) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        of_d = 1'b0;
        uf_d = 1'b0;
        nv_d = 1'b0;
        nx_d = 1'b0;
        case (s2_cls_q)
          CLS_NAN: begin
            o_d  = {s2_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
            nv_d = 1'b1;
          end
          CLS_INF:  o_d = {s2_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          CLS_ZERO: o_d = {s2_sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
          default: begin
            if (ovf) begin
              o_d  = {s2_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
              of_d = 1'b1;
              nx_d = 1'b1;
            end else if (unf) begin
              o_d  = {s2_sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
              uf_d = 1'b1;
              nx_d = 1'b1;
            end else begin
              o_d  = {s2_sign_q, exp_f[EXP_W-1:0], frac_f};
              nx_d = s2_inexact_q;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_cls_q     <= CLS_NUM;
      s1_exp_q     <= '0;
      s1_prod_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_cls_q     <= CLS_NUM;
      s2_exp_q     <= '0;
      s2_mant_q    <= '0;
      s2_inexact_q <= 1'b0;
      out_valid_q  <= 1'b0;
      o_q          <= '0;
      of_q         <= 1'b0;
      uf_q         <= 1'b0;
      nv_q         <= 1'b0;
      nx_q         <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_cls_q     <= s1_cls_d;
      s1_exp_q     <= s1_exp_d;
      s1_prod_q    <= s1_prod_d;
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_cls_q     <= s2_cls_d;
      s2_exp_q     <= s2_exp_d;
      s2_mant_q    <= s2_mant_d;
      s2_inexact_q <= s2_inexact_d;
      out_valid_q  <= out_valid_d;
      o_q          <= o_d;
      of_q         <= of_d;
      uf_q         <= uf_d;
      nv_q         <= nv_d;
      nx_q         <= nx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign o         = o_q;
  assign of        = of_q;
  assign uf        = uf_q;
  assign nv        = nv_q;
  assign nx        = nx_q;

endmodule
